// File: rtl/conv_mac_kxk.sv
// K x K signed convolution MAC: one kernel row per cycle, accumulated over CH
// channels, then bias, optional ReLU, saturation and per-row output gating.
module conv_mac_kxk #(
  parameter int K         = 5,
  parameter int DW        = 9,
  parameter int CH        = 1,
  parameter int OW        = 22,
  parameter int ROW_SLOTS = 32,
  parameter int ROW_OUT   = 28,
  parameter int RELU      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [K*K*DW-1:0]    x_win,
  input  logic [K*K*DW-1:0]    w_win,
  input  logic [DW-1:0]        bias,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [OW-1:0]        y_data,
  output logic                 y_sat
);
  localparam int ACC_W = 2*DW + $clog2(K*K*CH) + 1;
  localparam int SW    = (ACC_W + 1 > OW + 1) ? ACC_W + 1 : OW + 1;
  localparam int NE    = K*K;
  localparam int IW    = $clog2(NE + 1);
  localparam int RW    = $clog2(K + 1);
  localparam int CW    = $clog2(CH + 1);
  localparam int SLW   = $clog2(ROW_SLOTS + 1);

  localparam logic [RW-1:0]         R_LAST     = RW'(K - 1);
  localparam logic [CW-1:0]         CH_LAST    = CW'(CH - 1);
  localparam logic [SLW-1:0]        SLOT_LAST  = SLW'(ROW_SLOTS - 1);
  localparam logic [SLW-1:0]        ROW_OUT_L  = SLW'(ROW_OUT);
  localparam logic signed [SW-1:0]  MAX_V      = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0]  MIN_V      = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

  state_t                   state_q, state_d;
  logic [NE*DW-1:0]         x_q, x_d, w_q, w_d;
  logic signed [DW-1:0]     bias_q, bias_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            ch_q, ch_d;
  logic [SLW-1:0]           slot_q, slot_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]     y_data_q, y_data_d;
  logic                     y_sat_q, y_sat_d;
  logic                     y_valid_q, y_valid_d;

  logic signed [DW-1:0]     x_el [NE];
  logic signed [DW-1:0]     w_el [NE];
  logic signed [2*DW-1:0]   prod [K];
  logic [IW-1:0]            row_base;
  logic signed [ACC_W-1:0]  row_sum;
  logic signed [SW-1:0]     s_sum, s_relu;
  logic signed [OW-1:0]     s_clip;
  logic                     s_clipped;

  // Element 0 (row 0, col 0) lives at the MSBs of the packed window.
  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
      assign x_el[gi] = x_q[(NE-1-gi)*DW +: DW];
      assign w_el[gi] = w_q[(NE-1-gi)*DW +: DW];
    end
  endgenerate

  assign row_base = IW'(r_q) * IW'(K);

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_mul
      assign prod[gi] = x_el[row_base + IW'(gi)] * w_el[row_base + IW'(gi)];
    end
  endgenerate

  always_comb begin
    row_sum = '0;
    for (int c = 0; c < K; c++) begin
      row_sum = row_sum + {{(ACC_W-2*DW){prod[c][2*DW-1]}}, prod[c]};
    end
  end

  always_comb begin
    s_sum  = SW'(acc_q) + SW'(bias_q);
    s_relu = s_sum;
    if (RELU != 0 && s_sum[SW-1]) begin
      s_relu = '0;
    end
    s_clip    = s_relu[OW-1:0];
    s_clipped = 1'b0;
    if (s_relu > MAX_V) begin
      s_clip    = MAX_V[OW-1:0];
      s_clipped = 1'b1;
    end else if (s_relu < MIN_V) begin
      s_clip    = MIN_V[OW-1:0];
      s_clipped = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    bias_d    = bias_q;
    r_d       = r_q;
    ch_d      = ch_q;
    slot_d    = slot_q;
    acc_d     = acc_q;
    y_data_d  = y_data_q;
    y_sat_d   = y_sat_q;
    y_valid_d = y_valid_q;
    case (state_q)
      IDLE: begin
        if (x_valid) begin
          x_d = x_win;
          w_d = w_win;
          if (ch_q == '0) begin
            bias_d = bias;
          end
          r_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + row_sum;
        if (r_q == R_LAST) begin
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FIN;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      FIN: begin
        y_data_d  = s_clip;
        y_sat_d   = s_clipped;
        y_valid_d = (slot_q < ROW_OUT_L);
        state_d   = OUT;
      end
      OUT: begin
        // Padding slots never raise y_valid, so they fall through after one cycle.
        if (!y_valid_q || y_ready) begin
          acc_d     = '0;
          ch_d      = '0;
          slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      w_q       <= '0;
      bias_q    <= '0;
      r_q       <= '0;
      ch_q      <= '0;
      slot_q    <= '0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_sat_q   <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      w_q       <= w_d;
      bias_q    <= bias_d;
      r_q       <= r_d;
      ch_q      <= ch_d;
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      y_data_q  <= y_data_d;
      y_sat_q   <= y_sat_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign x_ready = (state_q == IDLE) && !rst;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_sat   = y_sat_q;
endmodule

// File: tb/tb_conv_mac_kxk.sv
// Bench for conv_mac_kxk: three instances (default, ReLU, CH=3/OW=16) checked
// against a scoreboard of model results.
module tb_conv_mac_kxk;
  localparam int K  = 5;
  localparam int DW = 9;
  localparam int NE = K*K;
  localparam int WW = NE*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst;
  logic [WW-1:0]  x_win, w_win;
  logic [DW-1:0]  bias;
  logic           y_ready;
  logic [2:0]     x_valid;
  wire  [2:0]     x_ready, y_valid, y_sat;
  wire  [21:0]    y_data0, y_data1;
  wire  [15:0]    y_data2;

  conv_mac_kxk u_dut0 (
    .clk(clk), .rst(rst), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
    .x_win(x_win), .w_win(w_win), .bias(bias), .y_valid(y_valid[0]),
    .y_ready(y_ready), .y_data(y_data0), .y_sat(y_sat[0]));
  conv_mac_kxk #(.RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
    .x_win(x_win), .w_win(w_win), .bias(bias), .y_valid(y_valid[1]),
    .y_ready(y_ready), .y_data(y_data1), .y_sat(y_sat[1]));
  conv_mac_kxk #(.CH(3), .OW(16)) u_dut2 (
    .clk(clk), .rst(rst), .x_valid(x_valid[2]), .x_ready(x_ready[2]),
    .x_win(x_win), .w_win(w_win), .bias(bias), .y_valid(y_valid[2]),
    .y_ready(y_ready), .y_data(y_data2), .y_sat(y_sat[2]));

  typedef struct {longint data; bit sat;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [WW-1:0] fill(logic [DW-1:0] v);
    return {NE{v}};
  endfunction

  function automatic longint dot(logic [WW-1:0] x, logic [WW-1:0] w);
    longint s = 0;
    for (int i = 0; i < NE; i++)
      s = s + longint'($signed(x[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    return s;
  endfunction

  function automatic exp_t fin(longint acc, logic [DW-1:0] b, int ow, bit relu);
    exp_t e;
    longint s = acc + longint'($signed(b));
    longint maxv = (64'sd1 <<< (ow - 1)) - 1;
    longint minv = -maxv - 1;
    if (relu && s < 0) s = 0;
    e.sat = 1'b0;
    if (s > maxv) begin s = maxv; e.sat = 1'b1; end
    else if (s < minv) begin s = minv; e.sat = 1'b1; end
    e.data = s;
    return e;
  endfunction

  function automatic longint ydat(int d);
    case (d)
      0: return longint'($signed(y_data0));
      1: return longint'($signed(y_data1));
      default: return longint'($signed(y_data2));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int d, input logic [WW-1:0] xw, input logic [WW-1:0] ww,
                      input logic [DW-1:0] b, output int t0);
    int n = 0;
    x_win = xw; w_win = ww; bias = b; x_valid[d] = 1'b1;
    while (!x_ready[d] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      $display("FAIL send_timeout: dut=%0d x_ready stayed 0 for %0d cycles", d, n);
      $fatal(1);
    end
    @(posedge clk);
    @(negedge clk);
    x_valid[d] = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_result(input int d, input int maxc, output bit got,
                             output longint data, output bit sat, output int at);
    got = 0; data = 0; sat = 0; at = 0;
    for (int n = 0; n < maxc; n++) begin
      if (y_valid[d]) begin
        got = 1; data = ydat(d); sat = y_sat[d]; at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; x_valid = '0; y_ready = 1'b1; x_win = '0; w_win = '0; bias = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (x_ready !== 3'b000) begin failures++; $display("FAIL reset_x_ready: got=%b want=000", x_ready); end
    checks++; if (y_valid !== 3'b000) begin failures++; $display("FAIL reset_y_valid: got=%b want=000", y_valid); end
    checks++; if (y_sat !== 3'b000) begin failures++; $display("FAIL reset_y_sat: got=%b want=000", y_sat); end
    checks++; if (y_data0 !== 22'd0 || y_data2 !== 16'd0) begin failures++; $display("FAIL reset_y_data: got=%h/%h want=0", y_data0, y_data2); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (x_ready !== 3'b111) begin failures++; $display("FAIL reset_idle_ready: got=%b want=111", x_ready); end
  endtask

  task automatic test_single();
    exp_t e; int t0, at; bit got, sat; longint data;
    sb.push_back(fin(dot(fill(9'd1), fill(9'd2)), 9'd3, 22, 0));
    send(0, fill(9'd1), fill(9'd2), 9'd3, t0);
    wait_result(0, 30, got, data, sat, at);
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL single_valid: got=0 want=1"); end
    checks++; if (at - t0 != 7) begin failures++; $display("FAIL single_latency: got=%0d want=7", at - t0); end
    checks++; if (data != e.data || sat != e.sat) begin failures++; $display("FAIL single_data: got=%0d/%0d want=%0d/%0d", data, sat, e.data, e.sat); end
    @(negedge clk);
  endtask

  task automatic test_signed_relu();
    exp_t e; int t0, at; bit got, sat; longint data;
    for (int d = 0; d < 2; d++) begin
      sb.push_back(fin(dot(fill(9'h1FF), fill(9'd255)), 9'd0, 22, d == 1));
      send(d, fill(9'h1FF), fill(9'd255), 9'd0, t0);
      wait_result(d, 30, got, data, sat, at);
      e = sb.pop_front();
      checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL signed_relu%0d: got=%0d/%0d/%0d want=1/%0d/%0d", d, got, data, sat, e.data, e.sat); end
      @(negedge clk);
    end
  endtask

  task automatic test_channels_sat();
    logic [DW-1:0] xs [3] = '{9'd255, 9'd1, 9'd255};
    logic [DW-1:0] ws [3] = '{9'd255, 9'd1, 9'h101};
    logic [DW-1:0] bs [3] = '{9'd5, 9'd7, 9'd20};
    exp_t e; int t0, at, n; bit got, sat; longint data;
    for (int c = 0; c < 3; c++) begin
      sb.push_back(fin(3 * dot(fill(xs[c]), fill(ws[c])), bs[c], 16, 0));
      for (int a = 0; a < 3; a++) begin
        send(2, fill(xs[c]), fill(ws[c]), (a == 0) ? bs[c] : bs[c] + 9'(a * 60), t0);
        if (a < 2) begin
          n = 0;
          while (!x_ready[2] && n < 20) begin @(negedge clk); n++; end
          checks++; if (cyc - t0 != K + 1) begin failures++; $display("FAIL ch_ready_timing%0d: got=%0d want=%0d", c, cyc - t0, K + 1); end
        end
      end
      wait_result(2, 30, got, data, sat, at);
      e = sb.pop_front();
      checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL channels%0d: got=%0d/%0d/%0d want=1/%0d/%0d", c, got, data, sat, e.data, e.sat); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int at [3]; int k = 0;
    for (int i = 0; i < 3; i++) sb.push_back(fin(dot(fill(9'd7), fill(9'h1FD)), 9'd11, 22, 0));
    x_win = fill(9'd7); w_win = fill(9'h1FD); bias = 9'd11; x_valid[0] = 1'b1;
    for (int n = 0; n < 100 && k < 3; n++) begin
      @(negedge clk);
      if (y_valid[0]) begin
        e = sb.pop_front();
        at[k] = cyc;
        checks++; if (ydat(0) != e.data || y_sat[0] != e.sat) begin failures++; $display("FAIL b2b_data%0d: got=%0d want=%0d", k, ydat(0), e.data); end
        k++;
        if (k == 3) x_valid[0] = 1'b0;
      end
    end
    x_valid[0] = 1'b0;
    checks++; if (k != 3) begin failures++; $display("FAIL b2b_count: got=%0d want=3", k); end
    else begin
      checks++; if (at[1] - at[0] != K + 3 || at[2] - at[1] != K + 3) begin failures++; $display("FAIL b2b_interval: got=%0d,%0d want=%0d", at[1] - at[0], at[2] - at[1], K + 3); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e; int t0, at; bit got, sat; longint data;
    y_ready = 1'b0;
    sb.push_back(fin(dot(fill(9'd12), fill(9'd9)), 9'h1F0, 22, 0));
    send(0, fill(9'd12), fill(9'd9), 9'h1F0, t0);
    wait_result(0, 30, got, data, sat, at);
    e = sb.pop_front();
    checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL bp_data: got=%0d/%0d want=1/%0d", got, data, e.data); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (y_valid[0] !== 1'b1 || ydat(0) != e.data || x_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_hold%0d: valid=%b data=%0d ready=%b want 1/%0d/0", i, y_valid[0], ydat(0), x_ready[0], e.data); end
    end
    y_ready = 1'b1;
    @(negedge clk);
    checks++; if (y_valid[0] !== 1'b0 || x_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", y_valid[0], x_ready[0]); end
    sb.push_back(fin(dot(fill(9'd4), fill(9'h1FE)), 9'd1, 22, 0));
    send(0, fill(9'd4), fill(9'h1FE), 9'd1, t0);
    wait_result(0, 30, got, data, sat, at);
    e = sb.pop_front();
    checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL bp_next: got=%0d/%0d want=1/%0d", got, data, e.data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e; int t0, at; bit got, sat; longint data;
    logic [WW-1:0] xr, wr; logic [DW-1:0] br;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NE; i++) begin
        xr[i*DW +: DW] = DW'($urandom);
        wr[i*DW +: DW] = DW'($urandom);
      end
      br = DW'($urandom);
      sb.push_back(fin(dot(xr, wr), br, 22, 0));
      send(0, xr, wr, br, t0);
      wait_result(0, 30, got, data, sat, at);
      e = sb.pop_front();
      checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL random%0d: got=%0d/%0d/%0d want=1/%0d/%0d", j, got, data, sat, e.data, e.sat); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mac();
    exp_t e; int t0, at; bit got, sat; longint data; bit stray = 0;
    send(0, fill(9'd100), fill(9'd100), 9'd0, t0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (y_valid[0] !== 1'b0 || y_data0 !== 22'd0 || y_sat[0] !== 1'b0 || x_ready[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs: valid=%b data=%h sat=%b ready=%b want all 0", y_valid[0], y_data0, y_sat[0], x_ready[0]); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (y_valid[0]) stray = 1;
    end
    checks++; if (stray) begin failures++; $display("FAIL rst_mid_stray: got y_valid=1 want 0"); end
    sb.push_back(fin(dot(fill(9'd3), fill(9'h1FF)), 9'd2, 22, 0));
    send(0, fill(9'd3), fill(9'h1FF), 9'd2, t0);
    wait_result(0, 30, got, data, sat, at);
    e = sb.pop_front();
    checks++; if (!got || data != e.data || sat != e.sat) begin failures++; $display("FAIL rst_mid_fresh: got=%0d/%0d want=1/%0d", got, data, e.data); end
    @(negedge clk);
  endtask

  task automatic test_row_gating();
    exp_t e; int t0; int slot = 0; bit seen, want, done; longint data;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    for (int i = 0; i < 93; i++) begin
      want = (slot < 28);
      if (want) sb.push_back(fin(dot(fill(9'd1), fill(9'd1)), 9'(i), 22, 0));
      send(0, fill(9'd1), fill(9'd1), 9'(i), t0);
      seen = 0; done = 0; data = 0;
      for (int n = 0; n < 20 && !done; n++) begin
        if (y_valid[0]) begin seen = 1; data = ydat(0); end
        if (x_ready[0]) done = 1;
        else @(negedge clk);
      end
      checks++; if (seen != want || !done) begin failures++; $display("FAIL row_gate%0d: valid=%0d want=%0d back_idle=%0d", i, seen, want, done); end
      if (want) begin
        e = sb.pop_front();
        if (seen) begin
          checks++; if (data != e.data) begin failures++; $display("FAIL row_data%0d: got=%0d want=%0d", i, data, e.data); end
        end
      end
      slot = (slot == 31) ? 0 : slot + 1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_signed_relu();
    test_channels_sat();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_mac();
    test_row_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
